rs_sqrt_iter: RTL and testbench

- Multicycle IEEE-754 single-precision square-root datapath.
- Computes the raw root magnitude ansS that feeds the root-select special-case stage directly downstream.
- Registers the operand and the 3-bit root select alongside the result, so the downstream stage sees an aligned {A, sel, ansS} set when done pulses.
- Ignores special values and sign; the downstream stage overrides those.

---
 rtl/rs_sqrt_iter.sv | 193 +++++++++++++++++++
 tb/tb_rs_sqrt_iter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rs_sqrt_iter.sv
// rs_sqrt_iter: multicycle single-precision square-root magnitude datapath.
// Produces the raw root ansS for the downstream root-select stage, together
// with the operand and root select that were captured when the operation
// started, so {A_q, sel_q, ansS} arrive as one aligned set when done pulses.
// Sign and special values (NaN, Inf) are not interpreted here; the
// downstream stage overrides them.
//
// Handshake: start is sampled only in IDLE. An accepted start captures A and
// sel, busy rises on the following cycle and stays high through CALC and
// ROUND, then done pulses for exactly one cycle (busy low) and the block
// returns to IDLE, where a new start may be accepted immediately. Starts seen
// while busy or during the done cycle are dropped, not queued.
//
// Timeline for a start sampled in cycle N:
//   N      : load (operand capture, exponent prep, radicand alignment)
//   N+1..25: CALC, one root bit per cycle, MSB first
//   N+26   : ROUND, ansS written
//   N+27   : DONE, done=1

module rs_sqrt_iter #(
    parameter bit ROUND_EN = 1'b1  // 1: round-to-nearest-even, 0: truncate
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [2:0]  sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] A_q,
    output logic [2:0]  sel_q,
    output logic [31:0] ansS
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of root bits: 1 hidden + 23 fraction + 1 guard.
    localparam logic [4:0] LAST_ITER = 5'd24;

    state_t      state;
    logic [49:0] radReg;    // radicand, consumed two bits per iteration from the top
    logic [24:0] rootReg;   // partial root, grows one bit per iteration
    logic [26:0] remReg;    // partial remainder, bounded by 2*root so 27 bits suffice
    logic [4:0]  iterCnt;   // iteration index 0..24
    logic [7:0]  expReg;    // biased result exponent before rounding carry
    logic        zeroFlag;  // operand exponent field was zero (zero or denormal)

    // ------------------------------------------------------------------
    // Exponent prep for the load cycle.
    // Result exponent is floor(E/2)+127 with E=e-127, which equals
    // floor((e+127)/2). The low bit of e+127 is set exactly when E is odd,
    // which is when the significand must be pre-shifted by one.
    // ------------------------------------------------------------------
    logic [8:0]  expSum;
    logic [7:0]  expLoad;
    logic        oddExp;
    logic [49:0] radLoad;

    // Derive the result exponent, odd/even flag and aligned radicand from A.
    always_comb begin
        expSum  = {1'b0, A[30:23]} + 9'd127;
        expLoad = expSum[8:1];
        oddExp  = expSum[0];
        // Left-align so the 50-bit integer root yields 25 significant bits:
        // even E -> significand * 2^25, odd E -> significand * 2^26.
        if (oddExp) begin
            radLoad = {1'b1, A[22:0], 26'd0};
        end else begin
            radLoad = {1'b0, 1'b1, A[22:0], 25'd0};
        end
    end

    // ------------------------------------------------------------------
    // One restoring digit-by-digit iteration:
    //   shifted = 4*rem + next two radicand bits
    //   trial   = shifted - (4*root + 1)
    //   if trial >= 0 the new root bit is 1 and trial becomes the remainder.
    // ------------------------------------------------------------------
    logic [28:0] remShift;
    logic [28:0] trialSub;
    logic        trialNeg;
    logic [26:0] remNext;

    // Compute the next remainder and root bit from the current partials.
    always_comb begin
        remShift = {remReg, radReg[49:48]};
        trialSub = {2'b00, rootReg, 2'b01};
        trialNeg = (remShift < trialSub);
        if (trialNeg) begin
            remNext = remShift[26:0];
        end else begin
            remNext = remShift[26:0] - trialSub[26:0];
        end
    end

    // ------------------------------------------------------------------
    // Rounding of the final 25-bit root into a 24-bit significand.
    // guard is the extra root bit; sticky is any nonzero final remainder.
    // ------------------------------------------------------------------
    logic        guardBit;
    logic        stickyBit;
    logic        roundInc;
    logic [23:0] fracSum;
    logic        sigCarry;
    logic [22:0] fracOut;
    logic [7:0]  expOut;
    logic [31:0] ansNext;

    // Assemble the rounded result word written during ROUND.
    always_comb begin
        guardBit  = rootReg[0];
        stickyBit = |remReg;
        roundInc  = ROUND_EN && guardBit && (stickyBit || rootReg[1]);
        fracSum   = {1'b0, rootReg[23:1]} + {23'd0, roundInc};
        // Fraction overflow with the hidden bit set carries out of the
        // 24-bit significand: fraction wraps to zero, exponent bumps.
        sigCarry  = fracSum[23] & rootReg[24];
        fracOut   = sigCarry ? 23'd0 : fracSum[22:0];
        expOut    = expReg + {7'd0, sigCarry};
        if (zeroFlag) begin
            ansNext = 32'h0000_0000;
        end else begin
            ansNext = {1'b0, expOut, fracOut};
        end
    end

    // Control FSM and datapath registers; outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            A_q      <= 32'd0;
            sel_q    <= 3'd0;
            ansS     <= 32'd0;
            radReg   <= 50'd0;
            rootReg  <= 25'd0;
            remReg   <= 27'd0;
            iterCnt  <= 5'd0;
            expReg   <= 8'd0;
            zeroFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        A_q      <= A;
                        sel_q    <= sel;
                        radReg   <= radLoad;
                        rootReg  <= 25'd0;
                        remReg   <= 27'd0;
                        iterCnt  <= 5'd0;
                        expReg   <= expLoad;
                        zeroFlag <= (A[30:23] == 8'd0);
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    remReg  <= remNext;
                    rootReg <= {rootReg[23:0], ~trialNeg};
                    radReg  <= {radReg[47:0], 2'b00};
                    if (iterCnt == LAST_ITER) begin
                        state <= ROUND;
                    end else begin
                        iterCnt <= iterCnt + 5'd1;
                    end
                end
                ROUND: begin
                    ansS  <= ansNext;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_sqrt_iter.sv
// Directed bench for rs_sqrt_iter. Two instances share all inputs: one
// rounding to nearest-even, one truncating. Inputs are driven and outputs
// sampled on the falling clock edge.

module tb_rs_sqrt_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [2:0]  sel;

    logic        busy, done;
    logic [31:0] A_q, ansS;
    logic [2:0]  sel_q;

    logic        busyT, doneT;
    logic [31:0] A_qT, ansST;
    logic [2:0]  sel_qT;

    int checks = 0;
    int errors = 0;

    rs_sqrt_iter #(.ROUND_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .sel(sel),
        .busy(busy), .done(done), .A_q(A_q), .sel_q(sel_q), .ansS(ansS)
    );

    rs_sqrt_iter #(.ROUND_EN(1'b0)) dutT (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .sel(sel),
        .busy(busyT), .done(doneT), .A_q(A_qT), .sel_q(sel_qT), .ansS(ansST)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one operation starting at a falling edge; ends at the falling
    // edge of the cycle after done (an IDLE cycle).
    task automatic runOp(input string tag, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] expR, input logic [31:0] expT);
        int cyc;
        start = 1'b1;
        A     = a;
        sel   = s;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            end
        end while (!done && cyc < 100);
        chk({tag, "_lat"}, 32'(cyc), 32'd27);
        chk({tag, "_ans"}, ansS, expR);
        chk({tag, "_ansT"}, ansST, expT);
        chk({tag, "_aq"}, A_q, a);
        chk({tag, "_selq"}, {29'd0, sel_q}, {29'd0, s});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    endtask

    int d1, d2, nDone, unstable;
    logic [31:0] ans1, ans2;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = 32'd0;
        sel   = 3'd0;
        repeat (2) @(negedge clk);

        // Reset state.
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ans", ansS, 32'd0);
        chk("rst_aq", A_q, 32'd0);
        chk("rst_selq", {29'd0, sel_q}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact roots, rounding cases, sign and zero.
        runOp("four",   32'h4080_0000, 3'b010, 32'h4000_0000, 32'h4000_0000);
        runOp("nine",   32'h4110_0000, 3'b010, 32'h4040_0000, 32'h4040_0000);
        runOp("two",    32'h4000_0000, 3'b101, 32'h3FB5_04F3, 32'h3FB5_04F3);
        runOp("three",  32'h4040_0000, 3'b001, 32'h3FDD_B3D7, 32'h3FDD_B3D7);
        runOp("rndup",  32'h3F80_0002, 3'b111, 32'h3F80_0001, 32'h3F80_0000);
        runOp("negfour",32'hC080_0000, 3'b011, 32'h4000_0000, 32'h4000_0000);
        runOp("denorm", 32'h0000_0001, 3'b100, 32'h0000_0000, 32'h0000_0000);

        // Reset in the middle of CALC aborts immediately.
        start = 1'b1;
        A     = 32'h4110_0000;
        sel   = 3'b110;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ans", ansS, 32'd0);
        chk("midrst_aq", A_q, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nDone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) nDone++;
        end
        chk("midrst_no_done", 32'(nDone), 32'd0);
        runOp("one", 32'h3F80_0000, 3'b000, 32'h3F80_0000, 32'h3F80_0000);

        // start held high 40 cycles with A changing every cycle.
        d1 = -1;
        d2 = -1;
        nDone = 0;
        for (int t = 0; t < 70; t++) begin
            if (t < 40) begin
                start = 1'b1;
                A     = 32'h4080_0000 + 32'(t << 12);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                nDone++;
                if (d1 < 0) begin
                    d1 = t + 1;
                end else if (d2 < 0) begin
                    d2 = t + 1;
                end
            end
            if (t + 1 == 1)  chk("hs_aq_first", A_q, 32'h4080_0000);
            if (t + 1 == 27) chk("hs_ans1", ansS, 32'h4000_0000);
            if (t + 1 == 28) chk("hs_aq_held", A_q, 32'h4080_0000);
            if (t + 1 == 29) chk("hs_aq_second", A_q, 32'h4080_0000 + 32'(28 << 12));
        end
        chk("hs_d1", 32'(d1), 32'd27);
        chk("hs_d2", 32'(d2), 32'd55);
        chk("hs_ndone", 32'(nDone), 32'd2);

        // Back-to-back operations: 4.0 then 9.0.
        d1 = -1;
        d2 = -1;
        unstable = 0;
        ans1 = 32'd0;
        ans2 = 32'd0;
        start = 1'b1;
        A     = 32'h4080_0000;
        for (int t = 0; t < 60; t++) begin
            if (t == 1)  A = 32'h4110_0000;
            if (t == 29) start = 1'b0;
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = t + 1;
                    ans1 = ansS;
                end else if (d2 < 0) begin
                    d2 = t + 1;
                    ans2 = ansS;
                end
            end
            if (t + 1 >= 27 && t + 1 <= 54 && ansS !== 32'h4000_0000) unstable++;
        end
        chk("b2b_gap", 32'(d2 - d1), 32'd28);
        chk("b2b_ans1", ans1, 32'h4000_0000);
        chk("b2b_ans2", ans2, 32'h4040_0000);
        chk("b2b_stable", 32'(unstable), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
